// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch queue state encoding and entry type
package cpu_pkg;
  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 16;
  typedef enum logic [1:0] {Q_EMPTY = 2'd0, Q_ONE = 2'd1, Q_FULL = 2'd2} qstate_e;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  addr;
  } entry_t;
  function automatic logic [1:0] q_count(qstate_e s);
    return s == Q_FULL ? 2'd2 : s == Q_ONE ? 2'd1 : 2'd0;
  endfunction
  function automatic qstate_e q_state(logic [1:0] n);
    return n == 2'd0 ? Q_EMPTY : n == 2'd1 ? Q_ONE : Q_FULL;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry {instr, addr} buffer, slot0 is the head
module fetch_queue
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     push_e,
  input  logic       pop,
  input  logic       flush,
  output entry_t     head,
  output logic [1:0] occ
);
  entry_t s0_q, s0_d, s1_q, s1_d;
  qstate_e st_q, st_d;
  logic [1:0] kept;
  // a push lands in the lowest slot left free after this cycle's pop
  always_comb begin
    kept = q_count(st_q) - {1'b0, pop && st_q != Q_EMPTY};
    s0_d = (pop && st_q == Q_FULL) ? s1_q : s0_q;
    s1_d = s1_q;
    if (push && kept == 2'd0) s0_d = push_e;
    if (push && kept != 2'd0) s1_d = push_e;
    st_d = flush ? Q_EMPTY : q_state(kept + {1'b0, push});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
      st_q <= Q_EMPTY;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      st_q <= st_d;
    end
  end
  assign head = s0_q;
  assign occ  = q_count(st_q);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, single in-flight code read tracking and read issue
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_ir_consume,
  input  logic               in_pc_load,
  input  logic [ADDR_W-1:0]  in_pc_value,
  input  logic [INSTR_W-1:0] in_code_data,
  output logic               out_code_rd_en,
  output logic [ADDR_W-1:0]  out_code_addr,
  output logic [INSTR_W-1:0] out_ir,
  output logic               out_ir_valid,
  output logic [ADDR_W-1:0]  out_ir_pc,
  output logic               out_busy
);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, inflight_addr_q, inflight_addr_d;
  logic inflight_q, inflight_d, issue;
  logic [1:0] occ;
  entry_t head;
  // a redirect squashes the returning word and suppresses issue this cycle
  always_comb begin
    issue = !reset && !in_pc_load &&
            (occ + {1'b0, inflight_q} < 2'd2 || (in_ir_consume && occ != 2'd0));
    fetch_pc_d = in_pc_load ? in_pc_value : issue ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
    inflight_d = issue;
    inflight_addr_d = issue ? fetch_pc_q : inflight_addr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end
  fetch_queue u_queue (
    .clk   (clk),
    .rst   (reset),
    .push  (inflight_q && !in_pc_load),
    .push_e('{instr: in_code_data, addr: inflight_addr_q}),
    .pop   (in_ir_consume && !in_pc_load),
    .flush (in_pc_load),
    .head  (head),
    .occ   (occ)
  );
  assign out_code_rd_en = issue;
  assign out_code_addr  = fetch_pc_q;
  assign out_ir         = head.instr;
  assign out_ir_pc      = head.addr;
  assign out_ir_valid   = occ != 2'd0;
  assign out_busy       = occ != 2'd2 || inflight_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus against a queue-based fetch model
module tb_fetch_unit;
  logic clk = 0, reset = 1, in_ir_consume = 0, in_pc_load = 0;
  logic [8:0] in_pc_value = '0;
  logic [15:0] in_code_data = '0;
  logic out_code_rd_en, out_ir_valid, out_busy;
  logic [8:0] out_code_addr, out_ir_pc;
  logic [15:0] out_ir;
  int n_vec = 0, n_err = 0;
  bit chk = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .in_ir_consume(in_ir_consume), .in_pc_load(in_pc_load),
    .in_pc_value(in_pc_value), .in_code_data(in_code_data), .out_code_rd_en(out_code_rd_en),
    .out_code_addr(out_code_addr), .out_ir(out_ir), .out_ir_valid(out_ir_valid),
    .out_ir_pc(out_ir_pc), .out_busy(out_busy)
  );

  function automatic logic [15:0] mem_at(int a);
    return 16'h1000 + 16'(a);
  endfunction

  // code memory: one-cycle read latency, garbage on the bus when not reading
  always @(posedge clk)
    in_code_data <= out_code_rd_en ? mem_at(int'(out_code_addr)) : 16'($urandom);

  typedef struct { logic [15:0] instr; int addr; } ent_t;
  ent_t q[$];
  bit m_inf = 0;
  int m_inf_addr = 0, m_pc = 0, m_ir_pc = 0;
  logic [15:0] m_ir = '0;

  function automatic bit exp_rd();
    return !reset && !in_pc_load &&
           ((q.size() + int'(m_inf) < 2) || (in_ir_consume && q.size() > 0));
  endfunction

  always @(posedge clk) begin
    bit iss;
    iss = exp_rd();
    if (reset) begin
      q.delete(); m_inf = 0; m_pc = 0; m_inf_addr = 0; m_ir = '0; m_ir_pc = 0;
    end else if (in_pc_load) begin
      q.delete(); m_inf = 0; m_pc = int'(in_pc_value);
    end else begin
      if (in_ir_consume && q.size() > 0) void'(q.pop_front());
      if (m_inf) q.push_back('{mem_at(m_inf_addr), m_inf_addr});
      m_inf = iss;
      if (iss) begin m_inf_addr = m_pc; m_pc = (m_pc + 1) % 512; end
      if (q.size() > 0) begin m_ir = q[0].instr; m_ir_pc = q[0].addr; end
    end
  end

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk) begin
    cmp("rd_en", 32'(out_code_rd_en), 32'(exp_rd()));
    cmp("code_addr", 32'(out_code_addr), m_pc);
    cmp("ir_valid", 32'(out_ir_valid), 32'(q.size() > 0));
    cmp("ir", 32'(out_ir), 32'(m_ir));
    cmp("ir_pc", 32'(out_ir_pc), m_ir_pc);
    cmp("busy", 32'(out_busy), 32'(q.size() < 2 || m_inf));
  end

  task automatic drive(bit r, bit c, bit l, int v);
    @(posedge clk);
    #1;
    reset = r; in_ir_consume = c; in_pc_load = l; in_pc_value = 9'(v);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk = 1;
    drive(0, 0, 0, 0); @(negedge clk);
    cmp("c0_rd", 32'(out_code_rd_en), 1); cmp("c0_addr", 32'(out_code_addr), 0);
    cmp("c0_valid", 32'(out_ir_valid), 0);
    drive(0, 0, 0, 0); @(negedge clk);
    cmp("c1_rd", 32'(out_code_rd_en), 1); cmp("c1_addr", 32'(out_code_addr), 1);
    drive(0, 0, 0, 0); @(negedge clk);
    cmp("c2_valid", 32'(out_ir_valid), 1); cmp("c2_ir", 32'(out_ir), 32'h1000);
    cmp("c2_pc", 32'(out_ir_pc), 0);
    drive(0, 0, 0, 0); @(negedge clk);
    cmp("c3_rd", 32'(out_code_rd_en), 0); cmp("c3_busy", 32'(out_busy), 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 0); @(negedge clk);
      cmp("stream_ir", 32'(out_ir), 32'h1000 + i); cmp("stream_valid", 32'(out_ir_valid), 1);
    end
    drive(0, 0, 0, 0); @(negedge clk);
    cmp("stream_last", 32'(out_ir), 32'h1006);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 511); @(negedge clk);
    cmp("ld_rd", 32'(out_code_rd_en), 0);
    drive(0, 0, 0, 0); @(negedge clk);
    cmp("ld1_valid", 32'(out_ir_valid), 0); cmp("ld1_addr", 32'(out_code_addr), 511);
    cmp("ld1_rd", 32'(out_code_rd_en), 1);
    drive(0, 0, 0, 0); @(negedge clk);
    cmp("ld2_addr", 32'(out_code_addr), 0); cmp("ld2_rd", 32'(out_code_rd_en), 1);
    drive(0, 1, 0, 0); @(negedge clk);
    cmp("ld3_ir", 32'(out_ir), 32'h11FF); cmp("ld3_pc", 32'(out_ir_pc), 511);
    cmp("ld3_valid", 32'(out_ir_valid), 1);
    drive(0, 1, 1, 100); @(negedge clk);
    cmp("wrap_ir", 32'(out_ir), 32'h1000); cmp("wrap_pc", 32'(out_ir_pc), 0);
    drive(0, 1, 0, 0); @(negedge clk);
    cmp("lc1_valid", 32'(out_ir_valid), 0); cmp("lc1_addr", 32'(out_code_addr), 100);
    drive(0, 1, 0, 0); @(negedge clk);
    cmp("lc2_valid", 32'(out_ir_valid), 0); cmp("lc2_addr", 32'(out_code_addr), 101);
    drive(0, 0, 0, 0); @(negedge clk);
    cmp("lc3_valid", 32'(out_ir_valid), 1); cmp("lc3_ir", 32'(out_ir), 32'h1064);
    cmp("lc3_pc", 32'(out_ir_pc), 100);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0); @(negedge clk);
    cmp("rst_rd", 32'(out_code_rd_en), 0);
    drive(0, 0, 0, 0); @(negedge clk);
    cmp("rst_valid", 32'(out_ir_valid), 0); cmp("rst_ir", 32'(out_ir), 0);
    cmp("rst_pc", 32'(out_ir_pc), 0); cmp("rst_addr", 32'(out_code_addr), 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0); @(negedge clk);
    cmp("rst_ir2", 32'(out_ir), 32'h1000);
    repeat (3000) begin
      bit r, c, l;
      int v;
      r = $urandom_range(0, 99) == 0;
      c = $urandom_range(0, 1) == 1;
      l = $urandom_range(0, 9) == 0;
      v = ($urandom_range(0, 3) == 0) ? 511 : int'($urandom_range(0, 511));
      drive(r, c, l, v);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
